// File: rtl/fetch_if.sv
// Fetch-stage signal bundle: icache request/response, pipeline control and IF/ID latch outputs.
interface fetch_if;
    logic        ihit;
    logic [31:0] iload;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic        ifid_valid;
    logic        halted;

    // master: the fetch stage itself
    modport master (
        input  ihit, iload, stall, redirect, redirect_pc, halt,
        output imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid, halted
    );

    // slave: icache / decode / control environment around the fetch stage
    modport slave (
        output ihit, iload, stall, redirect, redirect_pc, halt,
        input  imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid, halted
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, icache request, IF/ID latch and a one-entry skid for stalled hits.
//
// state  | meaning
// FETCH  | requesting icache at PC, loading IF/ID on hit
// HOLD   | hit returned while decode stalled; instruction parked in skid
// HALTED | halt decoded; fetch stopped until reset
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic      CLK,
    input  logic      nRST,
    fetch_if.master   fif
);
    typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] skid, skid_n;
    logic [31:0] instr, instr_n;
    logic [31:0] npc, npc_n;
    logic        valid, valid_n;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;

    assign pc_plus4     = pc + 32'd4;
    assign redirect_tgt = fif.redirect_pc & ~32'h3;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= FETCH;
            pc    <= RESET_PC;
            skid  <= '0;
            instr <= '0;
            npc   <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            skid  <= skid_n;
            instr <= instr_n;
            npc   <= npc_n;
            valid <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        skid_n  = skid;
        instr_n = instr;
        npc_n   = npc;
        valid_n = valid;
        // redirect outranks halt, stall and ihit everywhere except HALTED
        if (state != HALTED && fif.redirect) begin
            pc_n    = redirect_tgt;
            valid_n = 1'b0;
            skid_n  = '0;
            state_n = FETCH;
        end else if (state != HALTED && fif.halt) begin
            valid_n = 1'b0;
            state_n = HALTED;
        end else begin
            case (state)
                FETCH: begin
                    if (fif.ihit && !fif.stall) begin
                        instr_n = fif.iload;
                        npc_n   = pc_plus4;
                        valid_n = 1'b1;
                        pc_n    = pc_plus4;
                    end else if (fif.ihit && fif.stall) begin
                        skid_n  = fif.iload;
                        state_n = HOLD;
                    end else if (!fif.stall) begin
                        valid_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (!fif.stall) begin
                        instr_n = skid;
                        npc_n   = pc_plus4;
                        valid_n = 1'b1;
                        pc_n    = pc_plus4;
                        state_n = FETCH;
                    end
                end
                default: begin
                    valid_n = 1'b0;
                end
            endcase
        end
    end

    assign fif.imemREN    = (state == FETCH);
    assign fif.halted     = (state == HALTED);
    assign fif.imemaddr   = pc;
    assign fif.ifid_instr = instr;
    assign fif.ifid_npc   = npc;
    assign fif.ifid_valid = valid;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: scenario tasks with inline checks plus a scoreboard of expected IF/ID deliveries.
module tb_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] npc;
    } deliv_t;

    logic CLK;
    logic nRST;
    int   checks;
    int   failures;
    bit   mon_en;
    deliv_t sb[$];
    logic        prev_valid;
    logic [31:0] prev_npc;

    fetch_if fif ();

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .fif  (fif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // A new IF/ID delivery shows as ifid_valid rising or ifid_npc changing while valid.
    always @(negedge CLK) begin
        deliv_t e;
        if (mon_en && nRST) begin
            if (fif.ifid_valid && (!prev_valid || fif.ifid_npc !== prev_npc)) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got instr=%h npc=%h, required no delivery",
                             fif.ifid_instr, fif.ifid_npc);
                end else begin
                    e = sb.pop_front();
                    if (fif.ifid_instr !== e.instr || fif.ifid_npc !== e.npc) begin
                        failures++;
                        $display("FAIL sb_deliver: got instr=%h npc=%h, required instr=%h npc=%h",
                                 fif.ifid_instr, fif.ifid_npc, e.instr, e.npc);
                    end
                end
            end
            prev_valid = fif.ifid_valid;
            prev_npc   = fif.ifid_npc;
        end else begin
            prev_valid = 1'b0;
            prev_npc   = 32'h0;
        end
    end

    task automatic drive(input logic ih, input logic [31:0] il, input logic st,
                         input logic rd, input logic [31:0] rpc, input logic hl);
        fif.ihit        = ih;
        fif.iload       = il;
        fif.stall       = st;
        fif.redirect    = rd;
        fif.redirect_pc = rpc;
        fif.halt        = hl;
    endtask

    task automatic expect_deliv(input logic [31:0] instr, input logic [31:0] npc);
        deliv_t d;
        d.instr = instr;
        d.npc   = npc;
        sb.push_back(d);
    endtask

    task automatic edge_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        checks++;
        if (fif.imemREN !== 1'b1 || fif.halted !== 1'b0 || fif.ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got ren=%b halted=%b valid=%b, required 1 0 0",
                     fif.imemREN, fif.halted, fif.ifid_valid);
        end
        checks++;
        if (fif.imemaddr !== RST_PC || fif.ifid_instr !== 32'h0 || fif.ifid_npc !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got addr=%h instr=%h npc=%h, required %h 0 0",
                     fif.imemaddr, fif.ifid_instr, fif.ifid_npc, RST_PC);
        end
        edge_step();
        edge_step();
        nRST   = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] words[4] = '{32'h2001_0005, 32'h2002_0006, 32'h3000_0003, 32'h4000_0004};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (fif.imemaddr !== 32'(i * 4)) begin
                failures++;
                $display("FAIL seq_addr%0d: got %h, required %h", i, fif.imemaddr, 32'(i * 4));
            end
            drive(1'b1, words[i], 1'b0, 1'b0, 32'h0, 1'b0);
            expect_deliv(words[i], 32'((i + 1) * 4));
            edge_step();
            checks++;
            if (fif.ifid_valid !== 1'b1 || fif.ifid_npc !== 32'((i + 1) * 4)) begin
                failures++;
                $display("FAIL seq_valid%0d: got valid=%b npc=%h, required 1 %h",
                         i, fif.ifid_valid, fif.ifid_npc, 32'((i + 1) * 4));
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        edge_step();
        checks++;
        if (fif.ifid_valid !== 1'b0 || fif.imemaddr !== 32'h10 || fif.imemREN !== 1'b1) begin
            failures++;
            $display("FAIL bubble: got valid=%b addr=%h ren=%b, required 0 00000010 1",
                     fif.ifid_valid, fif.imemaddr, fif.imemREN);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 32'hAABB_CCDD, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            edge_step();
            checks++;
            if (fif.imemREN !== 1'b0 || fif.imemaddr !== 32'h10 || fif.ifid_valid !== 1'b0 ||
                fif.ifid_instr !== 32'h4000_0004 || fif.ifid_npc !== 32'h10) begin
                failures++;
                $display("FAIL hold%0d: got ren=%b addr=%h valid=%b instr=%h npc=%h, required 0 10 0 40000004 10",
                         i, fif.imemREN, fif.imemaddr, fif.ifid_valid, fif.ifid_instr, fif.ifid_npc);
            end
            drive(1'b1, 32'h0BAD_0000 + 32'(i), 1'b1, 1'b0, 32'h0, 1'b0);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_deliv(32'hAABB_CCDD, 32'h14);
        edge_step();
        checks++;
        if (fif.ifid_instr !== 32'hAABB_CCDD || fif.ifid_npc !== 32'h14 || fif.ifid_valid !== 1'b1 ||
            fif.imemaddr !== 32'h14 || fif.imemREN !== 1'b1) begin
            failures++;
            $display("FAIL unstall: got instr=%h npc=%h valid=%b addr=%h ren=%b, required aabbccdd 14 1 14 1",
                     fif.ifid_instr, fif.ifid_npc, fif.ifid_valid, fif.imemaddr, fif.imemREN);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        edge_step();
        checks++;
        if (fif.ifid_valid !== 1'b1 || fif.imemaddr !== 32'h14 || fif.imemREN !== 1'b1) begin
            failures++;
            $display("FAIL miss_stall: got valid=%b addr=%h ren=%b, required 1 14 1",
                     fif.ifid_valid, fif.imemaddr, fif.imemREN);
        end
    endtask

    task automatic test_redirect();
        drive(1'b1, 32'hCAFE_0001, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
        edge_step();
        checks++;
        if (fif.imemaddr !== 32'h100 || fif.ifid_valid !== 1'b0 || fif.imemREN !== 1'b1) begin
            failures++;
            $display("FAIL redirect: got addr=%h valid=%b ren=%b, required 100 0 1",
                     fif.imemaddr, fif.ifid_valid, fif.imemREN);
        end
        drive(1'b1, 32'hDEAD_0001, 1'b1, 1'b0, 32'h0, 1'b0);
        edge_step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_001C, 1'b0);
        edge_step();
        checks++;
        if (fif.imemaddr !== 32'h1C || fif.ifid_valid !== 1'b0 || fif.imemREN !== 1'b1) begin
            failures++;
            $display("FAIL redirect_hold: got addr=%h valid=%b ren=%b, required 1c 0 1",
                     fif.imemaddr, fif.ifid_valid, fif.imemREN);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        edge_step();
        checks++;
        if (fif.ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL skid_flushed: got valid=%b, required 0", fif.ifid_valid);
        end
        drive(1'b1, 32'h1C1C_1C1C, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_deliv(32'h1C1C_1C1C, 32'h20);
        edge_step();
    endtask

    task automatic test_halt();
        drive(1'b1, 32'h1111_2222, 1'b0, 1'b0, 32'h0, 1'b1);
        edge_step();
        checks++;
        if (fif.ifid_valid !== 1'b0 || fif.halted !== 1'b1 || fif.imemREN !== 1'b0 ||
            fif.imemaddr !== 32'h20) begin
            failures++;
            $display("FAIL halt: got valid=%b halted=%b ren=%b addr=%h, required 0 1 0 20",
                     fif.ifid_valid, fif.halted, fif.imemREN, fif.imemaddr);
        end
        drive(1'b1, 32'h3333_4444, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
        edge_step();
        edge_step();
        checks++;
        if (fif.imemaddr !== 32'h20 || fif.halted !== 1'b1 || fif.ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL halted_ignore: got addr=%h halted=%b valid=%b, required 20 1 0",
                     fif.imemaddr, fif.halted, fif.ifid_valid);
        end
    endtask

    task automatic test_wrap();
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (fif.halted !== 1'b0 || fif.imemREN !== 1'b1 || fif.imemaddr !== RST_PC) begin
            failures++;
            $display("FAIL reset_from_halt: got halted=%b ren=%b addr=%h, required 0 1 %h",
                     fif.halted, fif.imemREN, fif.imemaddr, RST_PC);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        edge_step();
        nRST = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        edge_step();
        checks++;
        if (fif.imemaddr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_setup: got addr=%h, required fffffffc", fif.imemaddr);
        end
        drive(1'b1, 32'h0000_0055, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_deliv(32'h0000_0055, 32'h0);
        edge_step();
        checks++;
        if (fif.ifid_npc !== 32'h0 || fif.imemaddr !== 32'h0 || fif.ifid_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap: got npc=%h addr=%h valid=%b, required 0 0 1",
                     fif.ifid_npc, fif.imemaddr, fif.ifid_valid);
        end
    endtask

    task automatic test_reset_hold();
        drive(1'b1, 32'h0000_0077, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_deliv(32'h0000_0077, 32'h4);
        edge_step();
        drive(1'b1, 32'hBADB_AD00, 1'b1, 1'b0, 32'h0, 1'b0);
        edge_step();
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (fif.ifid_valid !== 1'b0 || fif.ifid_instr !== 32'h0 || fif.ifid_npc !== 32'h0 ||
            fif.imemREN !== 1'b1 || fif.imemaddr !== RST_PC || fif.halted !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got valid=%b instr=%h npc=%h ren=%b addr=%h halted=%b, required 0 0 0 1 %h 0",
                     fif.ifid_valid, fif.ifid_instr, fif.ifid_npc, fif.imemREN, fif.imemaddr,
                     fif.halted, RST_PC);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        edge_step();
        nRST = 1'b1;
        edge_step();
        checks++;
        if (fif.ifid_valid !== 1'b0 || fif.ifid_instr === 32'hBADB_AD00 || fif.imemaddr !== RST_PC) begin
            failures++;
            $display("FAIL skid_after_reset: got valid=%b instr=%h addr=%h, required 0 not-badbad00 %h",
                     fif.ifid_valid, fif.ifid_instr, fif.imemaddr, RST_PC);
        end
        drive(1'b1, 32'h0000_0099, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_deliv(32'h0000_0099, RST_PC + 32'h4);
        edge_step();
        checks++;
        if (fif.imemaddr !== RST_PC + 32'h4 || fif.ifid_instr !== 32'h0000_0099) begin
            failures++;
            $display("FAIL resume: got addr=%h instr=%h, required %h 00000099",
                     fif.imemaddr, fif.ifid_instr, RST_PC + 32'h4);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        edge_step();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        mon_en     = 1'b0;
        prev_valid = 1'b0;
        prev_npc   = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_hold();
        @(negedge CLK);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending deliveries, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ihit  input  1  icache returns valid instruction for imemaddr this cycle.
REQ-005 SHALL have port iload  input  32  instruction word from icache, valid only when ihit=1.
REQ-006 SHALL have port stall  input  1  decode stage not accepting; IF/ID contents held.
REQ-007 SHALL have port redirect  input  1  branch/jump resolved taken; flush and refetch.
REQ-008 SHALL have port redirect_pc  input  32  target PC for redirect.
REQ-009 SHALL have port halt  input  1  HALT instruction decoded; stop fetching.
REQ-010 SHALL have port imemREN  output  1  icache read request.
REQ-011 SHALL have port imemaddr  output  32  icache read address, equals current PC.
REQ-012 SHALL have port ifid_instr  output  32  IF/ID latched instruction.
REQ-013 SHALL have port ifid_npc  output  32  IF/ID latched PC+4 of that instruction.
REQ-014 SHALL have port ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-015 SHALL have port halted  output  1  fetch stopped by halt.

Function
REQ-016 SHALL implement states FETCH, HOLD, HALTED, with one 32-bit skid register for an instruction returned while stalled.
REQ-017 SHALL in FETCH drive imemREN=1, imemaddr=PC; in HOLD and HALTED drive imemREN=0, imemaddr=PC.
REQ-018 SHALL in FETCH with ihit=1, stall=0: ifid_instr<=iload, ifid_npc<=PC+4, ifid_valid<=1, PC<=PC+4, stay FETCH.
REQ-019 SHALL in FETCH with ihit=1, stall=1: skid<=iload, IF/ID unchanged, PC unchanged, go HOLD.
REQ-020 SHALL in FETCH with ihit=0, stall=0: ifid_valid<=0 (bubble), instr/npc don't-care-held, PC unchanged.
REQ-021 SHALL in FETCH with ihit=0, stall=1: hold all IF/ID registers and PC.
REQ-022 SHALL in HOLD with stall=1: hold everything; with stall=0: ifid_instr<=skid, ifid_npc<=PC+4, ifid_valid<=1, PC<=PC+4, go FETCH.
REQ-023 SHALL treat redirect=1 as highest priority after reset, in any state except HALTED, overriding stall and ihit: PC<={redirect_pc[31:2],2'b00}, ifid_valid<=0, skid discarded, go FETCH.
REQ-024 SHALL treat halt=1 (redirect=0) in FETCH or HOLD as: ifid_valid<=0, go HALTED, PC held; any same-cycle ihit discarded.
REQ-025 SHALL in HALTED hold halted=1, ifid_valid=0, ignore redirect/stall/ihit/halt until reset.
REQ-026 SHALL compute PC+4 modulo 2^32 (0xFFFF_FFFC+4 -> 0x0000_0000), no overflow flag.
REQ-027 SHALL register ifid_* outputs; halted and imemREN are decoded from state combinationally; no combinational path from ihit/iload to any output.
REQ-028 SHALL deliver an instruction to IF/ID one rising edge after the ihit cycle (latency 1) when not stalled.

Reset
REQ-029 SHALL on nRST=0, asynchronously: PC<=RESET_PC, state<=FETCH, ifid_instr<=0, ifid_npc<=0, ifid_valid<=0, skid<=0; so imemREN=1, halted=0 while in reset.
REQ-030 SHALL on reset assertion mid-operation (including HOLD or HALTED) discard pending skid/state and resume fetching RESET_PC on first edge after release.

Verification
REQ-031 SHALL cover reset then ihit=1 every cycle, iload=0x2001_0005,0x2002_0006: ifid_npc 0x4 then 0x8, ifid_valid=1, imemaddr 0x0,0x4,0x8.
REQ-032 SHALL cover stall=1 with ihit=1 at PC=0x10, iload=0xAABB_CCDD, stall held 3 cycles: imemREN=0 during HOLD, IF/ID unchanged; stall drops -> ifid_instr=0xAABB_CCDD, ifid_npc=0x14, next imemaddr=0x14.
REQ-033 SHALL cover redirect=1, redirect_pc=0x0000_0103, stall=1, ihit=1 same cycle: next imemaddr=0x100, ifid_valid=0, state FETCH.
REQ-034 SHALL cover halt=1 at PC=0x20 with ihit=1: ifid_valid=0, halted=1, imemREN=0, later redirect=1 ignored (imemaddr stays 0x20).
REQ-035 SHALL cover PC=0xFFFF_FFFC with ihit=1, stall=0: ifid_npc=0x0000_0000, imemaddr=0x0.
REQ-036 SHALL cover nRST pulse low mid-HOLD: outputs reset immediately without a clock edge, imemaddr=RESET_PC, skid instruction never appears on ifid_instr.
